regfile8_clr: RTL

Eight-entry, WIDTH-bit register file with one write port, two combinational read ports and a sequenced bulk-clear engine. The 3-bit write address drives a 3-to-8 one-hot decoder whose Enable input is `wr_en & ~busy`. The decoded one-hot lines are the per-register load strobes. The block sits directly downstream of that decoder and holds the game's working state (timer snapshots, scores, LED patterns) for the control FSM.

---
 rtl/regfile8_clr.sv | 125 ++++++++++++
 1 files changed

// File: rtl/regfile8_clr.sv
// regfile8_clr: eight-entry register file with one write port, two
// combinational read ports and a sequenced bulk-clear engine.
// Optional build macro: REGFILE_BYPASS_EN (write-through forwarding on reads).
module regfile8_clr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [2:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             clr_start,
    output logic             busy,
    output logic             clr_done,
    output logic             wr_drop
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state_reg;
    logic [2:0]       cnt_reg;
    logic             busy_reg;
    logic             clr_done_reg;
    logic             wr_drop_reg;
    logic [WIDTH-1:0] regs [8];

    // Decoder enable: writes are only honoured while no sweep is running.
    logic             wr_accept;
    logic [7:0]       wr_strobe;
    logic [7:0]       clr_strobe;

    assign wr_accept = wr_en & ~busy_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg
            // 3-to-8 decode of the write address and of the sweep pointer.
            assign wr_strobe[gi]  = wr_accept & (wr_addr == 3'(gi));
            assign clr_strobe[gi] = (state_reg == CLEAR) & (cnt_reg == 3'(gi));

            // Per-register storage; clear and write strobes are mutually
            // exclusive because writes are gated off while sweeping.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs[gi] <= '0;
                end else if (clr_strobe[gi]) begin
                    regs[gi] <= '0;
                end else if (wr_strobe[gi]) begin
                    regs[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // Clear sequencer: one register zeroed per edge, done pulse after reg 7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= 3'd0;
            busy_reg     <= 1'b0;
            clr_done_reg <= 1'b0;
        end else begin
            clr_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (clr_start) begin
                        state_reg <= CLEAR;
                        cnt_reg   <= 3'd0;
                        busy_reg  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clr_start is deliberately ignored here: no restart, no queueing.
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg == 3'd7) begin
                        state_reg    <= IDLE;
                        busy_reg     <= 1'b0;
                        clr_done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Rejected-write flag, high for the cycle after a write hit a busy sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_drop_reg <= 1'b0;
        end else begin
            wr_drop_reg <= wr_en & busy_reg;
        end
    end

    assign busy     = busy_reg;
    assign clr_done = clr_done_reg;
    assign wr_drop  = wr_drop_reg;

`ifdef REGFILE_BYPASS_EN
    // Write-through forwarding: an accepted write is visible in the same cycle.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
        if (wr_accept && (rd_addr_a == wr_addr)) rd_data_a = wr_data;
        if (wr_accept && (rd_addr_b == wr_addr)) rd_data_b = wr_data;
    end
`else
    // Plain read muxes: stored contents only.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
    end
`endif

endmodule
